// File: rtl/score_keeper.sv
// Multi-team scoreboard: applies one +1/+2/+3/clear/undo command per key_score
// rising edge, keeps a bounded LIFO undo history and live leader/tie flags.
module score_keeper #(
  parameter int TEAMS      = 2,
  parameter int SCORE_W    = 8,
  parameter int UNDO_DEPTH = 4,
  parameter int SAT        = 1,
  parameter int TSEL_W     = $clog2(TEAMS),
  localparam int HCNT_W    = $clog2(UNDO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     key_score,
  input  logic [TSEL_W-1:0]        team,
  input  logic                     three_point,
  input  logic                     two_point,
  input  logic                     one_point,
  input  logic                     Reset_Score,
  input  logic                     undo,
  output logic [TEAMS*SCORE_W-1:0] score_bus,
  output logic [TSEL_W-1:0]        leader,
  output logic                     tie,
  output logic [HCNT_W-1:0]        hist_cnt,
  output logic                     ack,
  output logic                     err
);

  localparam int PTR_W = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;

  logic               key_q, key_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [SCORE_W-1:0] score_q      [TEAMS];
  logic [SCORE_W-1:0] score_d      [TEAMS];
  logic [TSEL_W-1:0]  hist_team_q  [UNDO_DEPTH];
  logic [TSEL_W-1:0]  hist_team_d  [UNDO_DEPTH];
  logic [SCORE_W-1:0] hist_score_q [UNDO_DEPTH];
  logic [SCORE_W-1:0] hist_score_d [UNDO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [HCNT_W-1:0]  cnt_q, cnt_d;

  logic               strobe;
  logic               team_ok;
  logic               any_add;
  logic [1:0]         add_n;
  logic [SCORE_W-1:0] old_score;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_score;
  logic [PTR_W-1:0]   pop_idx;
  logic [PTR_W-1:0]   push_nxt;
  logic [SCORE_W-1:0] max_score;

  always_comb begin
    strobe       = key_score & ~key_q;
    key_d        = key_score;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    score_d      = score_q;
    hist_team_d  = hist_team_q;
    hist_score_d = hist_score_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;

    team_ok = (int'(team) < TEAMS);
    any_add = Reset_Score | three_point | two_point | one_point;

    old_score = '0;
    for (int k = 0; k < TEAMS; k++) begin
      if (TSEL_W'(k) == team) old_score = score_q[k];
    end

    add_n = three_point ? 2'd3 : (two_point ? 2'd2 : 2'd1);
    sum   = {1'b0, old_score} + (SCORE_W + 1)'(add_n);
    if (Reset_Score)
      new_score = '0;
    else if ((SAT != 0) && sum[SCORE_W])
      new_score = '1;
    else
      new_score = sum[SCORE_W-1:0];

    // History is a ring: wr_ptr points at the next free slot, the newest entry sits just behind it.
    pop_idx  = (wr_ptr_q == '0) ? PTR_W'(UNDO_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
    push_nxt = (wr_ptr_q == PTR_W'(UNDO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

    if (strobe) begin
      if (undo) begin
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          for (int k = 0; k < TEAMS; k++) begin
            if (TSEL_W'(k) == hist_team_q[pop_idx]) score_d[k] = hist_score_q[pop_idx];
          end
          wr_ptr_d = pop_idx;
          cnt_d    = cnt_q - HCNT_W'(1);
          ack_d    = 1'b1;
        end
      end else if (any_add) begin
        if (!team_ok) begin
          err_d = 1'b1;
        end else begin
          for (int k = 0; k < TEAMS; k++) begin
            if (TSEL_W'(k) == team) score_d[k] = new_score;
          end
          hist_team_d[wr_ptr_q]  = team;
          hist_score_d[wr_ptr_q] = old_score;
          wr_ptr_d = push_nxt;
          if (cnt_q != HCNT_W'(UNDO_DEPTH)) cnt_d = cnt_q + HCNT_W'(1);
          ack_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      key_q    <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < TEAMS; k++) score_q[k] <= '0;
      for (int i = 0; i < UNDO_DEPTH; i++) begin
        hist_team_q[i]  <= '0;
        hist_score_q[i] <= '0;
      end
    end else begin
      key_q        <= key_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      hist_team_q  <= hist_team_d;
      hist_score_q <= hist_score_d;
    end
  end

  // Lowest index wins on equal maxima; tie is any other team matching that maximum.
  always_comb begin
    max_score = score_q[0];
    leader    = '0;
    for (int k = 1; k < TEAMS; k++) begin
      if (score_q[k] > max_score) begin
        max_score = score_q[k];
        leader    = TSEL_W'(k);
      end
    end
    tie = 1'b0;
    for (int k = 0; k < TEAMS; k++) begin
      if ((score_q[k] == max_score) && (TSEL_W'(k) != leader)) tie = 1'b1;
    end
  end

  for (genvar g = 0; g < TEAMS; g++) begin : g_bus
    assign score_bus[g*SCORE_W +: SCORE_W] = score_q[g];
  end

  assign hist_cnt = cnt_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: a 2-team saturating instance and a 3-team wrapping
// instance share stimulus and are checked against an arithmetic model.
module tb_score_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [1:0] team_in = 2'd0;
  logic       p3 = 1'b0, p2 = 1'b0, p1 = 1'b0, rs = 1'b0, ud = 1'b0;

  logic [15:0] bus_a;
  logic        lead_a, tie_a, ack_a, err_a;
  logic [2:0]  hc_a;
  logic [23:0] bus_b;
  logic [1:0]  lead_b;
  logic        tie_b, ack_b, err_b;
  logic [1:0]  hc_b;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: index 0 = dut_a (2 teams, depth 4, saturating), 1 = dut_b (3 teams, depth 3, wrapping)
  int exp_sc  [2][3];
  int exp_ht  [2][4];
  int exp_hs  [2][4];
  int exp_hn  [2];
  int exp_ack [2];
  int exp_err [2];

  score_keeper #(.TEAMS(2), .SCORE_W(8), .UNDO_DEPTH(4), .SAT(1)) dut_a (
    .clk(clk), .Reset(rst), .key_score(key), .team(team_in[0]),
    .three_point(p3), .two_point(p2), .one_point(p1), .Reset_Score(rs), .undo(ud),
    .score_bus(bus_a), .leader(lead_a), .tie(tie_a), .hist_cnt(hc_a), .ack(ack_a), .err(err_a)
  );

  score_keeper #(.TEAMS(3), .SCORE_W(8), .UNDO_DEPTH(3), .SAT(0)) dut_b (
    .clk(clk), .Reset(rst), .key_score(key), .team(team_in),
    .three_point(p3), .two_point(p2), .one_point(p1), .Reset_Score(rs), .undo(ud),
    .score_bus(bus_b), .leader(lead_b), .tie(tie_b), .hist_cnt(hc_b), .ack(ack_b), .err(err_b)
  );

  function automatic int teams_of(input int m);
    return (m == 0) ? 2 : 3;
  endfunction

  function automatic int depth_of(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) exp_sc[m][k] = 0;
      exp_hn[m]  = 0;
      exp_ack[m] = 0;
      exp_err[m] = 0;
    end
  endtask

  task automatic clear_pulses();
    for (int m = 0; m < 2; m++) begin
      exp_ack[m] = 0;
      exp_err[m] = 0;
    end
  endtask

  task automatic model_strobe(input int m, input int t, input bit u, input bit r,
                              input bit a3, input bit a2, input bit a1);
    int old_v, new_v, n;
    exp_ack[m] = 0;
    exp_err[m] = 0;
    if (u) begin
      if (exp_hn[m] == 0) begin
        exp_err[m] = 1;
      end else begin
        exp_hn[m]--;
        exp_sc[m][exp_ht[m][exp_hn[m]]] = exp_hs[m][exp_hn[m]];
        exp_ack[m] = 1;
      end
    end else if (r || a3 || a2 || a1) begin
      if (t >= teams_of(m)) begin
        exp_err[m] = 1;
      end else begin
        old_v = exp_sc[m][t];
        n     = a3 ? 3 : (a2 ? 2 : 1);
        new_v = r ? 0 : old_v + n;
        if (new_v > 255) new_v = (m == 0) ? 255 : new_v - 256;
        if (exp_hn[m] == depth_of(m)) begin
          for (int i = 1; i < depth_of(m); i++) begin
            exp_ht[m][i-1] = exp_ht[m][i];
            exp_hs[m][i-1] = exp_hs[m][i];
          end
          exp_hn[m]--;
        end
        exp_ht[m][exp_hn[m]] = t;
        exp_hs[m][exp_hn[m]] = old_v;
        exp_hn[m]++;
        exp_sc[m][t] = new_v;
        exp_ack[m]   = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int mx, ld, cnt;
    for (int m = 0; m < 2; m++) begin
      mx = -1; ld = 0; cnt = 0;
      for (int k = 0; k < teams_of(m); k++) begin
        if (exp_sc[m][k] > mx) begin
          mx = exp_sc[m][k];
          ld = k;
        end
      end
      for (int k = 0; k < teams_of(m); k++) if (exp_sc[m][k] == mx) cnt++;
      if (m == 0) begin
        for (int k = 0; k < 2; k++)
          chk($sformatf("%s_a_score%0d", tag, k), int'(bus_a[k*8 +: 8]), exp_sc[0][k]);
        chk({tag, "_a_leader"}, int'(lead_a), ld);
        chk({tag, "_a_tie"},    int'(tie_a), (cnt >= 2) ? 1 : 0);
        chk({tag, "_a_hist"},   int'(hc_a), exp_hn[0]);
        chk({tag, "_a_ack"},    int'(ack_a), exp_ack[0]);
        chk({tag, "_a_err"},    int'(err_a), exp_err[0]);
      end else begin
        for (int k = 0; k < 3; k++)
          chk($sformatf("%s_b_score%0d", tag, k), int'(bus_b[k*8 +: 8]), exp_sc[1][k]);
        chk({tag, "_b_leader"}, int'(lead_b), ld);
        chk({tag, "_b_tie"},    int'(tie_b), (cnt >= 2) ? 1 : 0);
        chk({tag, "_b_hist"},   int'(hc_b), exp_hn[1]);
        chk({tag, "_b_ack"},    int'(ack_b), exp_ack[1]);
        chk({tag, "_b_err"},    int'(err_b), exp_err[1]);
      end
    end
  endtask

  task automatic scramble();
    team_in = 2'($urandom_range(3, 0));
    p3 = 1'($urandom_range(1, 0));
    p2 = 1'($urandom_range(1, 0));
    p1 = 1'($urandom_range(1, 0));
    rs = 1'($urandom_range(1, 0));
    ud = 1'($urandom_range(1, 0));
  endtask

  task automatic do_cmd(input int t, input bit u, input bit r, input bit a3,
                        input bit a2, input bit a1, input string tag);
    @(negedge clk);
    key = 1'b1; team_in = 2'(t); ud = u; rs = r; p3 = a3; p2 = a2; p1 = a1;
    @(negedge clk);
    model_strobe(0, t % 2, u, r, a3, a2, a1);
    model_strobe(1, t, u, r, a3, a2, a1);
    check_all(tag);
    key = 1'b0;
    scramble();
    @(negedge clk);
    clear_pulses();
    check_all({tag, "_idle"});
  endtask

  // Key rises in the same cycle as reset and stays high after release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key = 1'b1; p1 = 1'b1; p3 = 1'b1; ud = 1'b0; rs = 1'b0; team_in = 2'd0;
    model_reset();
    @(negedge clk);
    check_all("rst");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all("rst_hold");
    end
    key = 1'b0; p1 = 1'b0; p3 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    bit u, r, a3, a2, a1;

    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    do_reset();

    do_cmd(1, 0, 0, 1, 0, 0, "tp_p3_t1");
    do_cmd(0, 0, 0, 0, 1, 0, "tp_p2_t0");
    chk("tp_score1", int'(bus_a[15:8]), 3);
    chk("tp_score0", int'(bus_a[7:0]), 2);
    chk("tp_leader", int'(lead_a), 1);
    chk("tp_tie", int'(tie_a), 0);
    chk("tp_hist", int'(hc_a), 2);

    do_reset();
    for (int i = 0; i < 84; i++) do_cmd(0, 0, 0, 1, 0, 0, "ramp");
    do_cmd(0, 0, 0, 0, 1, 0, "ramp_p2");
    chk("sat_start_a", int'(bus_a[7:0]), 254);
    do_cmd(0, 0, 0, 1, 0, 0, "sat_p3");
    chk("sat_clamp_a", int'(bus_a[7:0]), 255);
    chk("wrap_b", int'(bus_b[7:0]), 1);
    do_cmd(0, 0, 0, 0, 0, 1, "sat_p1");
    chk("sat_hold_a", int'(bus_a[7:0]), 255);
    chk("sat_hist_a", int'(hc_a), 4);
    do_cmd(0, 1, 0, 0, 0, 0, "sat_undo1");
    do_cmd(0, 1, 0, 0, 0, 0, "sat_undo2");
    chk("sat_undo_a", int'(bus_a[7:0]), 254);
    chk("wrap_undo_b", int'(bus_b[7:0]), 254);

    do_reset();
    for (int i = 0; i < 6; i++) do_cmd(0, 0, 0, 0, 0, 1, "depth_p1");
    chk("depth_score", int'(bus_a[7:0]), 6);
    chk("depth_hist", int'(hc_a), 4);
    for (int i = 0; i < 5; i++) do_cmd(2, 1, 0, 0, 0, 0, "depth_undo");
    chk("depth_undo_score", int'(bus_a[7:0]), 2);
    chk("depth_undo_hist", int'(hc_a), 0);

    @(negedge clk);
    key = 1'b1; p1 = 1'b1; p2 = 1'b0; p3 = 1'b0; rs = 1'b0; ud = 1'b0; team_in = 2'd0;
    @(negedge clk);
    model_strobe(0, 0, 0, 0, 0, 0, 1);
    model_strobe(1, 0, 0, 0, 0, 0, 1);
    check_all("hold");
    repeat (9) begin
      scramble();
      @(negedge clk);
      clear_pulses();
      check_all("hold_n");
    end
    key = 1'b0;
    @(negedge clk);
    check_all("hold_rel");

    do_cmd(3, 0, 0, 0, 1, 0, "bad_team");
    do_cmd(2, 0, 1, 0, 0, 0, "clr_t2");
    do_cmd(0, 1, 0, 1, 0, 0, "undo_p3");
    do_cmd(1, 0, 0, 0, 0, 0, "noop");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(39, 0) == 0) begin
        do_reset();
      end else begin
        t  = $urandom_range(3, 0);
        u  = ($urandom_range(5, 0) == 0);
        r  = ($urandom_range(9, 0) == 0);
        a3 = 1'($urandom_range(1, 0));
        a2 = 1'($urandom_range(1, 0));
        a1 = 1'($urandom_range(1, 0));
        do_cmd(t, u, r, a3, a2, a1, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Parametrised multi-team scoreboard for the basketball controller. It accepts one scoring command per rising edge of the debounced `key_score` strobe and applies it to a selected team. Supported commands are +1/+2/+3, clear, and undo of the last change. It maintains a per-team score register, a bounded undo history, and live leader/tie flags for the display and announcer logic.

## Interface
Parameters:
- `TEAMS`, 2: number of teams; must be ≥ 2.
- `SCORE_W`, 8: bits per team score.
- `UNDO_DEPTH`, 4: number of undoable changes retained; must be ≥ 1.
- `SAT`, 1: 1 = adds saturate at 2^SCORE_W−1; 0 = adds wrap modulo 2^SCORE_W.
- `TSEL_W`, $clog2(TEAMS): team-select width (derived).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `key_score`  in  1  debounced command strobe; only its rising edge acts.
- `team`  in  TSEL_W  target team index, sampled on the strobe edge.
- `three_point`, `two_point`, `one_point`  in  1 each  add-point selects.
- `Reset_Score`  in  1  clears the selected team's score.
- `undo`  in  1  reverts the most recent recorded change, regardless of `team`.
- `score_bus`  out  TEAMS*SCORE_W  team k occupies bits [k*SCORE_W +: SCORE_W].
- `leader`  out  TSEL_W  index of the highest-scoring team.
- `tie`  out  1  high when two or more teams share the maximum score.
- `hist_cnt`  out  $clog2(UNDO_DEPTH+1)  number of entries in the undo history.
- `ack`  out  1  one-cycle pulse: a command was applied.
- `err`  out  1  one-cycle pulse: a command was rejected.

## Operation
- Edge detect: `key_q` registers `key_score`. A strobe is `key_score & ~key_q`. On reset, `key_q` is set to 1, so a key held through reset does not fire.
- Command priority on a strobe, evaluated in this order:
  1. `undo`
  2. `Reset_Score`
  3. `three_point`
  4. `two_point`
  5. `one_point`
- Exactly one command executes per strobe. A strobe with no select high is a no-op: no `ack`, no `err`.
- Add: `new = old + N`, where N is 3, 2 or 1.
  - SAT=1: if the SCORE_W+1-bit sum exceeds the maximum, the result clamps to all-ones.
  - SAT=0: the result is the low SCORE_W bits of the sum.
- Clear: the selected team's score becomes 0.
- History push: every applied add or clear pushes {team, old score}. This includes an add that leaves the score unchanged because it is already saturated.
  - History is a circular LIFO of UNDO_DEPTH entries.
  - When full, a push overwrites the oldest entry and `hist_cnt` stays at UNDO_DEPTH.
- Undo: pops the newest entry and writes the stored old score back to the stored team. `hist_cnt` decrements. An undo is never itself recorded.
- Undo with `hist_cnt`=0: rejected; pulses `err`; no state change.
- `team` ≥ TEAMS on an add or clear: rejected; pulses `err`; no push. This applies only when TEAMS is not a power of two. Undo ignores `team`.
- `leader`/`tie`: combinational from the score registers.
  - `leader` is the lowest index among the teams holding the maximum score.
  - `tie` = (count of teams at maximum) ≥ 2.
  - With all scores 0: `leader`=0, `tie`=1.
- Reset: all scores 0, history empty (`hist_cnt`=0), `ack`=0, `err`=0, `key_q`=1. Therefore `leader`=0 and `tie`=1.
- Reset asserted in the same cycle as a strobe: reset wins and the command is discarded.

## Timing
- Strobe detected in cycle N: the score, history and `hist_cnt` registers update at the end of cycle N. The new values are visible in cycle N+1.
- `ack`/`err` are high for exactly cycle N+1.
- `leader`/`tie` reflect new scores in cycle N+1, with no added latency.
- Throughput: a new strobe requires `key_score` low for ≥ 1 cycle, so at most one command every 2 cycles.
- Holding `key_score` high produces no further commands.
- Command inputs and `team` matter only in the strobe cycle. Other cycles ignore them.

## Test plan
- Reset, then three_point with team=1 strobe, then two_point with team=0 strobe → score1=3, score0=2, `leader`=1, `tie`=0, `hist_cnt`=2, one `ack` per strobe.
- SAT=1, SCORE_W=8: set score0=254, then three_point strobe → score0=255. A further one_point → 255 with `hist_cnt` incremented. Undo twice → 254.
- SAT=0, SCORE_W=8: score0=254, three_point strobe → score0=1.
- UNDO_DEPTH=4: six +1 strobes on team 0 → score0=6, `hist_cnt`=4. Five undos → score0=2, then `err` on the fifth undo, and `hist_cnt`=0.
- Hold `key_score` high for 10 cycles with one_point → exactly one increment. Hold `key_score` high across deassertion of `Reset` → no increment.
- TEAMS=3: strobe with team=3 and two_point → `err`, all scores unchanged, `hist_cnt` unchanged. Strobe with `undo` and three_point both high → undo executes, no add.
